// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Stall/flush sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// It resolves load-use hazards against ID/EX with a single bubble, freezes
// the whole pipeline while the data memory is busy, squashes wrong-path
// instructions on taken branches, and latches a sticky fault when a memory
// access does not complete within MEM_WAIT_MAX wait cycles.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN - builds a 16-bit saturating stall counter on
//                        Stall_Cnt. It counts every cycle with PC_En=0 while
//                        out of reset. Without the macro, Stall_Cnt is 0.
//
// Ports:
//   Clk, Rst_n             clock (rising edge), async active-low reset
//   ID_Rs, ID_Rt           source registers of the ID instruction
//   ID_UsesRs, ID_UsesRt   ID instruction actually reads Rs / Rt
//   ID_EX_MReg             EX instruction is a load
//   ID_EX_EnRW             EX instruction writes the register file
//   ID_EX_WN               destination register of the EX instruction
//   EX_MEM_MemAcc          MEM instruction accesses data memory
//   Mem_Ready              data memory completes the access this cycle
//   Branch_Taken           branch resolved taken in EX
//   PC_En, IF_ID_En, ID_EX_En, EX_MEM_En   pipeline register enables
//   IF_ID_Flush, ID_EX_Flush               clear to NOP / bubble
//   MEM_WB_Bubble          MEM/WB captures a bubble
//   Mem_Fault              sticky memory-timeout fault
//   Stall_Cnt              stall performance counter (optional)
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RUN       | normal flow; branch flush and load-use bubble handled here
//   MEM_WAIT  | pipeline frozen, waiting for the data memory to complete
//   FAULT     | memory timed out; pipeline held frozen until reset
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_BITS     = 4,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_BITS     = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [REG_BITS-1:0] ID_Rs,
    input  logic [REG_BITS-1:0] ID_Rt,
    input  logic                ID_UsesRs,
    input  logic                ID_UsesRt,
    input  logic                ID_EX_MReg,
    input  logic                ID_EX_EnRW,
    input  logic [REG_BITS-1:0] ID_EX_WN,
    input  logic                EX_MEM_MemAcc,
    input  logic                Mem_Ready,
    input  logic                Branch_Taken,
    output logic                PC_En,
    output logic                IF_ID_En,
    output logic                IF_ID_Flush,
    output logic                ID_EX_En,
    output logic                ID_EX_Flush,
    output logic                EX_MEM_En,
    output logic                MEM_WB_Bubble,
    output logic                Mem_Fault,
    output logic [15:0]         Stall_Cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    // Wait timer runs downward: the value loaded on entry to MEM_WAIT is the
    // number of further not-ready cycles tolerated before the terminal count.
    localparam logic [CNT_BITS-1:0] WAIT_LOAD = CNT_BITS'(MEM_WAIT_MAX - 1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] wait_left_q;
    logic                wait_load, wait_dec;

    logic                load_use;
    logic                mem_busy;
    logic                mem_release;

    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
    logic ex_mem_en_c, mem_wb_bubble_c;

    assign load_use = ID_EX_MReg & ID_EX_EnRW &
                      ((ID_UsesRs & (ID_Rs == ID_EX_WN)) |
                       (ID_UsesRt & (ID_Rt == ID_EX_WN)));

    assign mem_busy    = EX_MEM_MemAcc & ~Mem_Ready;
    // A dropped access request ends the wait just like a ready strobe.
    assign mem_release = ~EX_MEM_MemAcc | Mem_Ready;

    // ------------------------------------------------------------------------
    // State and wait timer
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_RUN;
            wait_left_q <= '0;
        end else begin
            state_q <= state_d;
            if (wait_load) begin
                wait_left_q <= WAIT_LOAD;
            end else if (wait_dec) begin
                wait_left_q <= wait_left_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and raw pipeline controls
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        wait_load       = 1'b0;
        wait_dec        = 1'b0;
        pc_en_c         = 1'b1;
        if_id_en_c      = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_en_c      = 1'b1;
        id_ex_flush_c   = 1'b0;
        ex_mem_en_c     = 1'b1;
        mem_wb_bubble_c = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_en_c         = 1'b0;
                    if_id_en_c      = 1'b0;
                    id_ex_en_c      = 1'b0;
                    ex_mem_en_c     = 1'b0;
                    mem_wb_bubble_c = 1'b1;
                    state_d         = ST_MEM_WAIT;
                    wait_load       = 1'b1;
                end else if (Branch_Taken) begin
                    // The ID instruction is on the wrong path, so its
                    // load-use hazard is irrelevant.
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_en_c       = 1'b0;
                    if_id_en_c    = 1'b0;
                    id_ex_flush_c = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_release) begin
                    state_d = ST_RUN;
                    if (Branch_Taken) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (load_use) begin
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end else begin
                    pc_en_c         = 1'b0;
                    if_id_en_c      = 1'b0;
                    id_ex_en_c      = 1'b0;
                    ex_mem_en_c     = 1'b0;
                    mem_wb_bubble_c = 1'b1;
                    if (wait_left_q == '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_dec = 1'b1;
                    end
                end
            end

            ST_FAULT: begin
                pc_en_c         = 1'b0;
                if_id_en_c      = 1'b0;
                id_ex_en_c      = 1'b0;
                ex_mem_en_c     = 1'b0;
                mem_wb_bubble_c = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: everything is held inactive while reset is asserted, so the
    // pipeline registers neither load nor flush during reset.
    // ------------------------------------------------------------------------
    assign PC_En         = Rst_n & pc_en_c;
    assign IF_ID_En      = Rst_n & if_id_en_c;
    assign IF_ID_Flush   = Rst_n & if_id_flush_c;
    assign ID_EX_En      = Rst_n & id_ex_en_c;
    assign ID_EX_Flush   = Rst_n & id_ex_flush_c;
    assign EX_MEM_En     = Rst_n & ex_mem_en_c;
    assign MEM_WB_Bubble = Rst_n & mem_wb_bubble_c;
    assign Mem_Fault     = (state_q == ST_FAULT);

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else if (!PC_En && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`else
    assign Stall_Cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs are driven 1 ns after the
// rising edge; outputs are sampled at the following falling edge.
module tb_pipe_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [3:0] ID_Rs, ID_Rt, ID_EX_WN;
    logic       ID_UsesRs, ID_UsesRt, ID_EX_MReg, ID_EX_EnRW;
    logic       EX_MEM_MemAcc, Mem_Ready, Branch_Taken;
    logic       PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush;
    logic       EX_MEM_En, MEM_WB_Bubble, Mem_Fault;
    logic [15:0] Stall_Cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush, EX_MEM_En,
    //  MEM_WB_Bubble, Mem_Fault}
    logic [7:0] obs;
    localparam logic [7:0] V_RESET  = 8'b0000_0000;
    localparam logic [7:0] V_NORMAL = 8'b1101_0100;
    localparam logic [7:0] V_FREEZE = 8'b0000_0010;
    localparam logic [7:0] V_LU     = 8'b0001_1100;
    localparam logic [7:0] V_BRANCH = 8'b1111_1100;
    localparam logic [7:0] V_FAULT  = 8'b0000_0011;

    assign obs = {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush,
                  EX_MEM_En, MEM_WB_Bubble, Mem_Fault};

    pipe_hazard_ctrl #(.REG_BITS(4), .MEM_WAIT_MAX(15), .CNT_BITS(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_EX_MReg(ID_EX_MReg), .ID_EX_EnRW(ID_EX_EnRW), .ID_EX_WN(ID_EX_WN),
        .EX_MEM_MemAcc(EX_MEM_MemAcc), .Mem_Ready(Mem_Ready),
        .Branch_Taken(Branch_Taken),
        .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_En(ID_EX_En), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_En(EX_MEM_En), .MEM_WB_Bubble(MEM_WB_Bubble),
        .Mem_Fault(Mem_Fault), .Stall_Cnt(Stall_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic quiet();
        ID_Rs = 4'h0; ID_Rt = 4'h0; ID_EX_WN = 4'h0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        ID_EX_MReg = 1'b0; ID_EX_EnRW = 1'b0;
        EX_MEM_MemAcc = 1'b0; Mem_Ready = 1'b0; Branch_Taken = 1'b0;
    endtask

    task automatic pulse_reset();
        step();
        Rst_n = 1'b0;
        quiet();
        step();
        Rst_n = 1'b1;
    endtask

    task automatic set_lu_rt();
        ID_EX_MReg = 1'b1; ID_EX_EnRW = 1'b1; ID_EX_WN = 4'h5;
        ID_Rt = 4'h5; ID_UsesRt = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            {ID_Rs, ID_Rt, ID_EX_WN} = 12'($urandom);
            {ID_UsesRs, ID_UsesRt, ID_EX_MReg, ID_EX_EnRW,
             EX_MEM_MemAcc, Mem_Ready, Branch_Taken} = 7'($urandom);
            sample();
            tests_run++;
            if (obs !== V_RESET) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, V_RESET);
            end
        end
        step();
        quiet();
        Rst_n = 1'b1;
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL reset_release: got %b expected %b", obs, V_NORMAL);
        end
    endtask

    task automatic test_load_use();
        step();
        set_lu_rt();
        sample();
        tests_run++;
        if (obs !== V_LU) begin
            tests_failed++;
            $display("FAIL lu_rt_stall: got %b expected %b", obs, V_LU);
        end
        // The bubble reaches EX: the hazard disappears.
        step();
        ID_EX_MReg = 1'b0; ID_EX_EnRW = 1'b0;
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL lu_after_bubble: got %b expected %b", obs, V_NORMAL);
        end
        step();
        set_lu_rt();
        ID_UsesRt = 1'b0;
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL lu_rt_unused: got %b expected %b", obs, V_NORMAL);
        end
        step();
        quiet();
        ID_EX_MReg = 1'b1; ID_EX_EnRW = 1'b1; ID_EX_WN = 4'h0;
        ID_Rs = 4'h0; ID_UsesRs = 1'b1;
        sample();
        tests_run++;
        if (obs !== V_LU) begin
            tests_failed++;
            $display("FAIL lu_rs_r0: got %b expected %b", obs, V_LU);
        end
        step();
        ID_EX_EnRW = 1'b0;
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL lu_no_write: got %b expected %b", obs, V_NORMAL);
        end
        step();
        ID_EX_EnRW = 1'b1; ID_Rs = 4'h3;
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL lu_reg_differs: got %b expected %b", obs, V_NORMAL);
        end
        step();
        quiet();
    endtask

    task automatic test_branch();
        step();
        set_lu_rt();
        Branch_Taken = 1'b1;
        sample();
        tests_run++;
        if (obs !== V_BRANCH) begin
            tests_failed++;
            $display("FAIL branch_over_lu: got %b expected %b", obs, V_BRANCH);
        end
        step();
        quiet();
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL branch_no_stall: got %b expected %b", obs, V_NORMAL);
        end
    endtask

    task automatic test_mem_wait();
        step();
        EX_MEM_MemAcc = 1'b1; Mem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Branch and hazard during the wait must not leak through.
            Branch_Taken = (i == 1);
            if (i == 2) set_lu_rt();
            sample();
            tests_run++;
            if (obs !== V_FREEZE) begin
                tests_failed++;
                $display("FAIL mem_freeze[%0d]: got %b expected %b", i, obs, V_FREEZE);
            end
            step();
        end
        quiet();
        EX_MEM_MemAcc = 1'b1; Mem_Ready = 1'b1;
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL mem_release: got %b expected %b", obs, V_NORMAL);
        end
        step();
        quiet();
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL mem_back_to_run: got %b expected %b", obs, V_NORMAL);
        end
        // Release with a taken branch in the same cycle; release by MemAcc drop.
        step();
        EX_MEM_MemAcc = 1'b1;
        step();
        EX_MEM_MemAcc = 1'b1; Mem_Ready = 1'b1; Branch_Taken = 1'b1;
        sample();
        tests_run++;
        if (obs !== V_BRANCH) begin
            tests_failed++;
            $display("FAIL mem_release_branch: got %b expected %b", obs, V_BRANCH);
        end
        step();
        quiet();
        EX_MEM_MemAcc = 1'b1;
        step();
        EX_MEM_MemAcc = 1'b0;
        set_lu_rt();
        sample();
        tests_run++;
        if (obs !== V_LU) begin
            tests_failed++;
            $display("FAIL mem_drop_release_lu: got %b expected %b", obs, V_LU);
        end
        // Reset in the middle of a wait abandons it.
        step();
        quiet();
        EX_MEM_MemAcc = 1'b1;
        step();
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        quiet();
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL mem_reset_midwait: got %b expected %b", obs, V_NORMAL);
        end
    endtask

    task automatic test_fault();
        logic [7:0] exp;
        step();
        EX_MEM_MemAcc = 1'b1; Mem_Ready = 1'b0;
        // One busy cycle in RUN plus 15 in MEM_WAIT, then FAULT.
        for (int i = 0; i < 18; i++) begin
            exp = (i < 16) ? V_FREEZE : V_FAULT;
            sample();
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL fault_timeout[%0d]: got %b expected %b", i, obs, exp);
            end
            step();
        end
        Mem_Ready = 1'b1;
        step();
        EX_MEM_MemAcc = 1'b0;
        sample();
        tests_run++;
        if (obs !== V_FAULT) begin
            tests_failed++;
            $display("FAIL fault_sticky: got %b expected %b", obs, V_FAULT);
        end
        step();
        Rst_n = 1'b0;
        #2;
        tests_run++;
        if (Mem_Fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_async_clear: got %b expected 0", Mem_Fault);
        end
        step();
        Rst_n = 1'b1;
        quiet();
        sample();
        tests_run++;
        if (obs !== V_NORMAL) begin
            tests_failed++;
            $display("FAIL fault_after_reset: got %b expected %b", obs, V_NORMAL);
        end
    endtask

    task automatic test_perf_cnt();
        logic [15:0] exp_cnt;
`ifdef HAZARD_PERF_CNT_EN
        exp_cnt = 16'd4;
`else
        exp_cnt = 16'd0;
`endif
        pulse_reset();
        EX_MEM_MemAcc = 1'b1; Mem_Ready = 1'b0;
        step();
        step();
        step();
        Mem_Ready = 1'b1;
        step();
        quiet();
        set_lu_rt();
        step();
        quiet();
        sample();
        tests_run++;
        if (Stall_Cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL perf_cnt: got %0d expected %0d", Stall_Cnt, exp_cnt);
        end
        pulse_reset();
        sample();
        tests_run++;
        if (Stall_Cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL perf_cnt_reset: got %0d expected 0", Stall_Cnt);
        end
    endtask

    initial begin
        quiet();
        Rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_fault();
        test_perf_cnt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
